// File: rtl/muldiv_unit_pkg.sv
// Shared encodings and op-class helpers for the HI/LO multiply/divide unit.
package muldiv_unit_pkg;

  localparam int MD_OP_W = 4;

  typedef enum logic [MD_OP_W-1:0] {
    MD_OTH   = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } md_op_e;

  // One bit per encoding; codes 11-15 are clear in every mask so they act as OTH.
  localparam logic [15:0] MULT_CLASS_MASK = 16'b0000_0111_1000_0110;
  localparam logic [15:0] DIV_CLASS_MASK  = 16'b0000_0000_0001_1000;
  localparam logic [15:0] ARITH_MASK      = MULT_CLASS_MASK | DIV_CLASS_MASK;

  function automatic logic is_arith(input logic [MD_OP_W-1:0] op);
    return ARITH_MASK[op];
  endfunction

  function automatic logic is_mult_class(input logic [MD_OP_W-1:0] op);
    return MULT_CLASS_MASK[op];
  endfunction

  function automatic logic is_div_class(input logic [MD_OP_W-1:0] op);
    return DIV_CLASS_MASK[op];
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Combinational HI/LO datapath: computes the committed hi/lo for a latched op.
module muldiv_core
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [MD_OP_W-1:0] op,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [DATA_W-1:0]  hi0,
  input  logic [DATA_W-1:0]  lo0,
  output logic [DATA_W-1:0]  hi_next,
  output logic [DATA_W-1:0]  lo_next
);

  localparam int W2 = 2 * DATA_W;

  logic [W2-1:0]     prod_s, prod_u, acc;
  logic [DATA_W-1:0] mag_a, mag_b, div_b, quo_u, rem_u, quo, rem;
  logic              signed_div, a_neg, b_neg;

  // Sign-extending to 2W bits makes the truncated product the exact signed product.
  assign prod_s = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
  assign prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  assign acc    = {hi0, lo0};

  // Signed divide runs on magnitudes; the most-negative dividend's magnitude
  // is representable as unsigned, so MIN / -1 wraps back to MIN naturally.
  assign signed_div = (op == MD_DIV);
  assign a_neg      = signed_div && a[DATA_W-1];
  assign b_neg      = signed_div && b[DATA_W-1];
  assign mag_a      = a_neg ? -a : a;
  assign mag_b      = b_neg ? -b : b;
  assign div_b      = (b == '0) ? DATA_W'(1) : mag_b;   // keep the divider defined on /0
  assign quo_u      = mag_a / div_b;
  assign rem_u      = mag_a % div_b;
  assign quo        = (a_neg ^ b_neg) ? -quo_u : quo_u;
  assign rem        = a_neg ? -rem_u : rem_u;

  // Select the result for the latched op; anything else leaves hi/lo as they were.
  always_comb begin
    hi_next = hi0;
    lo_next = lo0;
    case (op)
      MD_MULT:  {hi_next, lo_next} = prod_s;
      MD_MULTU: {hi_next, lo_next} = prod_u;
      MD_MADD:  {hi_next, lo_next} = acc + prod_s;
      MD_MADDU: {hi_next, lo_next} = acc + prod_u;
      MD_MSUB:  {hi_next, lo_next} = acc - prod_s;
      MD_MSUBU: {hi_next, lo_next} = acc - prod_u;
      MD_DIV, MD_DIVU: begin
        if (b != '0) begin
          hi_next = rem;
          lo_next = quo;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit: IDLE/RUN FSM, latency counter, HI/LO registers.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic               start,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  output logic               busy,
  output logic [DATA_W-1:0]  hi,
  output logic [DATA_W-1:0]  lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [MD_OP_W-1:0] op_reg, op_next;
  logic [DATA_W-1:0]  a_reg, a_next, b_reg, b_next;
  logic [DATA_W-1:0]  hi0_reg, hi0_next, lo0_reg, lo0_next;
  logic [DATA_W-1:0]  hi_reg, hi_next, lo_reg, lo_next;
  logic [DATA_W-1:0]  core_hi, core_lo;

  muldiv_core #(.DATA_W(DATA_W)) u_core (
    .op      (op_reg),
    .a       (a_reg),
    .b       (b_reg),
    .hi0     (hi0_reg),
    .lo0     (lo0_reg),
    .hi_next (core_hi),
    .lo_next (core_lo)
  );

  assign busy = (state_reg == RUN);
  assign hi   = hi_reg;
  assign lo   = lo_reg;

  // State, counter, latched operands and HI/LO; active-low reset aborts any run.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      hi0_reg   <= '0;
      lo0_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      hi0_reg   <= hi0_next;
      lo0_reg   <= lo0_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  // Launch, count down and commit; MTHI/MTLO only take effect while idle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    hi0_next   = hi0_reg;
    lo0_next   = lo0_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    case (state_reg)
      IDLE: begin
        if (start && is_arith(md_op)) begin
          op_next    = md_op;
          a_next     = a;
          b_next     = b;
          hi0_next   = hi_reg;
          lo0_next   = lo_reg;
          cnt_next   = is_mult_class(md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          state_next = RUN;
        end else if (md_op == MD_MTHI) begin
          hi_next = a;
        end else if (md_op == MD_MTLO) begin
          lo_next = a;
        end
      end
      RUN: begin
        // The counter holds the edges still to go; the last one commits.
        if (cnt_reg <= CNT_W'(1)) begin
          cnt_next   = '0;
          hi_next    = core_hi;
          lo_next    = core_lo;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: 32-bit default instance plus a 16-bit, 1-cycle instance.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  md_op = MD_OTH;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy;
  logic [31:0] hi, lo;

  logic [3:0]  md_op_n = MD_OTH;
  logic        start_n = 1'b0;
  logic [15:0] a_n = '0, b_n = '0;
  logic        busy_n;
  logic [15:0] hi_n, lo_n;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  bit   inject_ok = 1'b0;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .md_op(md_op), .start(start),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.DATA_W(16), .MULT_CYCLES(1), .DIV_CYCLES(10)) dut_n (
    .clk(clk), .reset(reset), .md_op(md_op_n), .start(start_n),
    .a(a_n), .b(b_n), .busy(busy_n), .hi(hi_n), .lo(lo_n)
  );

  always #5 clk = ~clk;

  // The pipeline stalls MD traffic while busy; only the deliberate injection may break that.
  always @(posedge clk) begin
    if (reset && !inject_ok && busy && (start || md_op == MD_MTHI || md_op == MD_MTLO))
      $error("MD stimulus issued while busy");
  end

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else n_pass++;
    n_checks++; if (hi !== 32'h0) $display("FAIL reset_hi got=%h want=0", hi); else n_pass++;
    n_checks++; if (lo !== 32'h0) $display("FAIL reset_lo got=%h want=0", lo); else n_pass++;
    n_checks++; if (busy_n !== 1'b0 || hi_n !== 16'h0 || lo_n !== 16'h0)
      $display("FAIL reset_narrow got=%b/%h/%h want=0/0/0", busy_n, hi_n, lo_n); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Drive MTHI/MTLO for one edge and confirm the register took the value.
  task automatic do_mt(input logic [3:0] op, input logic [31:0] val);
    md_op = op; a = val;
    @(posedge clk); @(negedge clk);
    md_op = MD_OTH; a = '0;
    n_checks++;
    if (op == MD_MTHI) begin
      if (hi !== val) $display("FAIL mthi got=%h want=%h", hi, val); else n_pass++;
    end else begin
      if (lo !== val) $display("FAIL mtlo got=%h want=%h", lo, val); else n_pass++;
    end
  endtask

  // Launch one arithmetic op, push its expectation, and check it when busy drops.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_cyc, input bit inject);
    exp_t e;
    logic [31:0] hi_old, lo_old;
    int cyc;
    bit stable;
    e.name = name; e.hi = exp_hi; e.lo = exp_lo; e.cycles = exp_cyc;
    hi_old = hi; lo_old = lo; stable = 1'b1; cyc = 0;
    md_op = op; a = av; b = bv; start = 1'b1;
    sb.push_back(e);
    @(posedge clk); @(negedge clk);
    start = 1'b0; md_op = MD_OTH; a = '0; b = '0;
    inject_ok = inject;
    while (busy && cyc < 60) begin
      cyc++;
      if (hi !== hi_old || lo !== lo_old) stable = 1'b0;
      if (inject && cyc == 2) begin
        md_op = MD_DIV; a = 32'd100; b = 32'd3; start = 1'b1;
      end else if (inject && cyc == 3) begin
        md_op = MD_MTHI; a = 32'h0000DEAD; b = '0; start = 1'b0;
      end else begin
        md_op = MD_OTH; a = '0; b = '0; start = 1'b0;
      end
      @(negedge clk);
    end
    md_op = MD_OTH; a = '0; b = '0; start = 1'b0;
    inject_ok = 1'b0;
    e = sb.pop_front();
    $display("op %s a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d", e.name, av, bv, hi, lo, cyc);
    n_checks++; if (cyc !== e.cycles) $display("FAIL %s_latency got=%0d want=%0d", e.name, cyc, e.cycles); else n_pass++;
    n_checks++; if (hi !== e.hi) $display("FAIL %s_hi got=%h want=%h", e.name, hi, e.hi); else n_pass++;
    n_checks++; if (lo !== e.lo) $display("FAIL %s_lo got=%h want=%h", e.name, lo, e.lo); else n_pass++;
    n_checks++; if (stable !== 1'b1) $display("FAIL %s_hold got=changed want=stable_while_busy", e.name); else n_pass++;
  endtask

  task automatic test_mult();
    run_op("mult",  MD_MULT,  32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, 1'b0);
    run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5, 1'b0);
  endtask

  task automatic test_div();
    run_op("div",     MD_DIV, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0);
    run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, 1'b0);
    run_op("divu",    MD_DIVU, 32'd100,     32'd7,        32'd2,        32'd14,       10, 1'b0);
  endtask

  task automatic test_div_zero();
    do_mt(MD_MTHI, 32'h11);
    do_mt(MD_MTLO, 32'h22);
    run_op("divu_zero", MD_DIVU, 32'd5, 32'd0, 32'h11, 32'h22, 10, 1'b0);
  endtask

  task automatic test_accumulate();
    do_mt(MD_MTLO, 32'd5);
    do_mt(MD_MTHI, 32'd0);
    run_op("madd",  MD_MADD,  32'd3, 32'd4,  32'h0,        32'd17,       5, 1'b0);
    run_op("msubu", MD_MSUBU, 32'd1, 32'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1'b0);
  endtask

  task automatic test_reset_abort();
    md_op = MD_MULT; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; md_op = MD_OTH; a = '0; b = '0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b want=0", busy); else n_pass++;
    n_checks++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL abort_clear got=%h_%h want=0_0", hi, lo); else n_pass++;
    reset = 1'b1;
    repeat (8) @(negedge clk);
    $display("op abort_mult -> hi=%h lo=%h busy=%b", hi, lo, busy);
    n_checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0)
      $display("FAIL abort_no_commit got=%b/%h/%h want=0/0/0", busy, hi, lo); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    run_op("mult_inject", MD_MULT, 32'd6, 32'd7, 32'h0, 32'd42, 5, 1'b1);
    // The ignored start must not have left a second run behind.
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'd42)
      $display("FAIL inject_after got=%b/%h/%h want=0/0/2a", busy, hi, lo); else n_pass++;
  endtask

  task automatic test_narrow();
    exp_t e;
    int cyc;
    e.name = "mult16"; e.hi = 32'h0000FFFF; e.lo = 32'h0000FFFE; e.cycles = 1;
    md_op_n = MD_MULT; a_n = 16'hFFFF; b_n = 16'd2; start_n = 1'b1;
    sb.push_back(e);
    @(posedge clk); @(negedge clk);
    md_op_n = MD_OTH; a_n = '0; b_n = '0; start_n = 1'b0;
    cyc = 0;
    while (busy_n && cyc < 30) begin
      cyc++;
      @(negedge clk);
    end
    e = sb.pop_front();
    $display("op %s a=ffff b=0002 -> hi=%h lo=%h busy_cycles=%0d", e.name, hi_n, lo_n, cyc);
    n_checks++; if (cyc !== e.cycles) $display("FAIL %s_latency got=%0d want=%0d", e.name, cyc, e.cycles); else n_pass++;
    n_checks++; if ({16'h0, hi_n} !== e.hi) $display("FAIL %s_hi got=%h want=%h", e.name, hi_n, e.hi); else n_pass++;
    n_checks++; if ({16'h0, lo_n} !== e.lo) $display("FAIL %s_lo got=%h want=%h", e.name, lo_n, e.lo); else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_accumulate();
    test_reset_abort();
    test_busy_ignore();
    test_narrow();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
